// File: rtl/bcd_pkg.sv
// Shared types and constants for the iterative BCD-to-binary converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DIGIT_W        = 4;
  localparam int BCD_MAX_DIGIT  = 9;
  localparam int BCD_SUB_THRESH = 8;
  localparam int BCD_SUB_VAL    = 3;

  // Smallest binary width that holds 10**digits - 1.
  function automatic int bcd_min_bin_w(input int digits);
    longint p;
    int     w;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    w = 0;
    for (int i = 0; i < 63; i++) if ((64'd1 << w) < p) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/bcd_digit_sub3.sv
// One BCD digit correction cell: digits of 8 or more have 3 subtracted after a
// right shift (mirror of the encoder's add-3 cell).
module bcd_digit_sub3
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d_i,
  output logic [DIGIT_W-1:0] d_o
);

  always_comb begin
    d_o = d_i;
    if (d_i >= DIGIT_W'(BCD_SUB_THRESH)) d_o = d_i - DIGIT_W'(BCD_SUB_VAL);
  end

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Iterative BCD-to-binary converter (reverse double-dabble), one step per clock.
// Optional invalid-digit check enabled by defining BCD_DIGIT_CHECK_EN.
module bcd_to_binary_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [4*DIGITS-1:0]     bcd_in,
  output logic                    ready,
  output logic                    busy,
  output logic                    done,
  output logic [BIN_W-1:0]        bin_out,
  output logic                    err
);

  localparam int BCD_W  = DIGIT_W * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);

  if (BIN_W < bcd_min_bin_w(DIGITS)) begin : g_bin_w_chk
    $error("bcd_to_binary_seq: BIN_W too small for DIGITS");
  end

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORK_W-1:0]   work_q, work_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [BIN_W-1:0]    bin_out_q, bin_out_d;
  logic                err_q, err_d;

  logic [WORK_W-1:0]   work_shr;
  logic [BCD_W-1:0]    bcd_corr;
  logic [WORK_W-1:0]   work_step;

  // Shift right first, then correct each BCD digit independently (no borrow).
  assign work_shr = work_q >> 1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_sub3 u_sub3 (
      .d_i (work_shr[BIN_W + i*DIGIT_W +: DIGIT_W]),
      .d_o (bcd_corr[i*DIGIT_W +: DIGIT_W])
    );
  end

  assign work_step = {bcd_corr, work_shr[BIN_W-1:0]};

`ifdef BCD_DIGIT_CHECK_EN
  function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (v[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(BCD_MAX_DIGIT)) bad = 1'b1;
    return bad;
  endfunction
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    bin_out_d = bin_out_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef BCD_DIGIT_CHECK_EN
          if (has_bad_digit(bcd_in)) begin
            state_d   = DONE;
            bin_out_d = '0;
            err_d     = 1'b1;
          end else begin
            state_d = SHIFT;
            work_d  = {bcd_in, {BIN_W{1'b0}}};
            cnt_d   = '0;
          end
`else
          state_d = SHIFT;
          work_d  = {bcd_in, {BIN_W{1'b0}}};
          cnt_d   = '0;
`endif
        end
      end
      SHIFT: begin
        work_d = work_step;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          state_d   = DONE;
          bin_out_d = work_step[BIN_W-1:0];
          err_d     = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Status outputs are registered copies of the next state.
    ready_d = (state_d == IDLE);
    busy_d  = (state_d == SHIFT);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bin_out_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bin_out_q <= bin_out_d;
      err_q     <= err_d;
    end
  end

  assign ready   = ready_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign bin_out = bin_out_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq (DIGITS=3, BIN_W=10).
module tb_bcd_to_binary_seq;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;

  logic              clk;
  logic              rst;
  logic              start;
  logic [11:0]       bcd_in;
  logic              ready;
  logic              busy;
  logic              done;
  logic [BIN_W-1:0]  bin_out;
  logic              err;

  int n_checks;
  int n_errors;
  int cyc;

  bcd_to_binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] bcd;
    int          exp_bin;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: decimal value of a packed BCD word.
  function automatic int bcd_value(input logic [11:0] b);
    int v;
    v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + int'(b[i*4 +: 4]);
    return v;
  endfunction

  // Launch one conversion from a negedge and wait for done. 'edge_n' is the
  // rising edge (counted from the accepting edge) at which done is sampled high.
  task automatic convert(input logic [11:0] bcd, output int bin, output int e,
                         output int edge_n, output int busy_cyc, output int done_cyc);
    int n;
    n = 0;
    while (!ready && n < 50) begin @(negedge clk); n++; end
    chk("ready_before_start", int'(ready), 1);
    bcd_in = bcd;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    bcd_in = 12'($urandom);
    n = 1;
    busy_cyc = 0;
    while (!done && n < 40) begin
      if (busy) busy_cyc++;
      chk("ready_low_while_active", int'(ready), 0);
      @(negedge clk);
      n++;
    end
    chk("done_seen", int'(done), 1);
    edge_n   = n;
    done_cyc = cyc;
    bin      = int'(bin_out);
    e        = int'(err);
    @(negedge clk);
    chk("done_single_pulse", int'(done), 0);
    chk("ready_after_done", int'(ready), 1);
    chk("bin_out_holds", int'(bin_out), bin);
  endtask

  initial begin
    int bin, e, edge_n, bc, dc, dc2;
    logic [11:0] rb;

    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    rst      = 1'b1;
    start    = 1'b0;
    bcd_in   = '0;

    vecs[0] = '{12'h255, 255};
    vecs[1] = '{12'h999, 999};
    vecs[2] = '{12'h000, 0};
    vecs[3] = '{12'h010, 10};
    vecs[4] = '{12'h001, 1};
    vecs[5] = '{12'h500, 500};
    vecs[6] = '{12'h098, 98};
    vecs[7] = '{12'h909, 909};
    vecs[8] = '{12'h888, 888};
    vecs[9] = '{12'h512, 512};

    repeat (2) @(negedge clk);
    chk("rst_ready", int'(ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_bin_out", int'(bin_out), 0);
    chk("rst_err", int'(err), 0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven conversions, including the 255 and 999 corners.
    for (int i = 0; i < 10; i++) begin
      convert(vecs[i].bcd, bin, e, edge_n, bc, dc);
      chk($sformatf("vec%0d_bin", i), bin, vecs[i].exp_bin);
      chk($sformatf("vec%0d_err", i), e, 0);
      chk($sformatf("vec%0d_done_edge", i), edge_n, BIN_W + 1);
      chk($sformatf("vec%0d_busy_cycles", i), bc, BIN_W);
    end

    // start during SHIFT and during DONE is ignored, not queued.
    bcd_in = 12'h123;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    edge_n = 1;
    while (!done && edge_n < 40) begin
      start  = (edge_n == 3);
      bcd_in = (edge_n == 3) ? 12'h456 : 12'h123;
      @(negedge clk);
      edge_n++;
    end
    chk("ign_done_seen", int'(done), 1);
    chk("ign_done_edge", edge_n, BIN_W + 1);
    chk("ign_bin", int'(bin_out), 123);
    start  = 1'b1;
    bcd_in = 12'h456;
    @(negedge clk);
    start  = 1'b0;
    chk("ign_ready_back", int'(ready), 1);
    @(negedge clk);
    chk("ign_not_queued_busy", int'(busy), 0);
    chk("ign_not_queued_ready", int'(ready), 1);
    chk("ign_bin_hold", int'(bin_out), 123);

    // Reset in the middle of SHIFT aborts at once.
    bcd_in = 12'h777;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", int'(ready), 1);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_bin", int'(bin_out), 0);
    @(negedge clk);
    rst = 1'b0;
    dc = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) dc++;
    end
    chk("aborted_no_done", dc, 0);
    convert(12'h042, bin, e, edge_n, bc, dc);
    chk("post_rst_bin", bin, 42);
    chk("post_rst_edge", edge_n, BIN_W + 1);

    // Invalid digit handling.
    convert(12'h1A3, bin, e, edge_n, bc, dc);
`ifdef BCD_DIGIT_CHECK_EN
    chk("bad_digit_err", e, 1);
    chk("bad_digit_bin", bin, 0);
    chk("bad_digit_edge", edge_n, 1);
    chk("bad_digit_busy", bc, 0);
    convert(12'h321, bin, e, edge_n, bc, dc);
    chk("err_cleared", e, 0);
    chk("err_clear_bin", bin, 321);
`else
    chk("bad_digit_err", e, 0);
    chk("bad_digit_edge", edge_n, BIN_W + 1);
`endif

    // Back-to-back: second start in the first ready cycle after done.
    convert(12'h500, bin, e, edge_n, bc, dc);
    chk("b2b_first", bin, 500);
    convert(12'h001, bin, e, edge_n, bc, dc2);
    chk("b2b_second", bin, 1);
    chk("b2b_spacing", dc2 - dc, BIN_W + 2);

    // Randomized valid operands against the decimal model.
    for (int k = 0; k < 30; k++) begin
      rb = '0;
      for (int d = 0; d < DIGITS; d++) rb[d*4 +: 4] = 4'($urandom_range(0, 9));
      convert(rb, bin, e, edge_n, bc, dc);
      chk($sformatf("rand%0d_bin_%03h", k, rb), bin, bcd_value(rb));
      chk($sformatf("rand%0d_err", k), e, 0);
      chk($sformatf("rand%0d_edge", k), edge_n, BIN_W + 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
